// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__pwr_pkg
// Shared states, constants and helpers for the power-switch sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu7t5v0__pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_UP     = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ON     = 3'd3,
    ST_DOWN   = 3'd4
  } pwr_state_t;

  localparam int PWR_SETTLE_TIMEOUT_MULT = 4;
  localparam int PWR_RAIL_DROP_CYCLES    = 2;

  function automatic logic pwr_is_busy(input pwr_state_t s);
    return (s == ST_UP) || (s == ST_SETTLE) || (s == ST_DOWN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if
// Request/switch/status bundle; RAIL_OK/FAULT exist only with
// GF180MCU_PWR_SEQ_RAIL_CHECK_EN defined.
// Rev 1.0
// ---------------------------------------------------------------------------
interface gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if #(
  parameter int NUM_STAGES = 8
);
  logic                  PWR_REQ;
  logic [NUM_STAGES-1:0] SW_EN;
  logic                  ISO_EN;
  logic                  PWR_GOOD;
  logic                  BUSY;
`ifdef GF180MCU_PWR_SEQ_RAIL_CHECK_EN
  logic                  RAIL_OK;
  logic                  FAULT;

  modport master (output PWR_REQ, RAIL_OK, input SW_EN, ISO_EN, PWR_GOOD, BUSY, FAULT);
  modport slave  (input PWR_REQ, RAIL_OK, output SW_EN, ISO_EN, PWR_GOOD, BUSY, FAULT);
`else
  modport master (output PWR_REQ, input SW_EN, ISO_EN, PWR_GOOD, BUSY);
  modport slave  (input PWR_REQ, output SW_EN, ISO_EN, PWR_GOOD, BUSY);
`endif
endinterface
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_seq_dly.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__pwr_seq_dly
// Loadable stage-delay counter: wraps at STAGE_DLY-1 and flags terminal count.
// Rev 1.0
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__pwr_seq_dly #(
  parameter int STAGE_DLY = 16,
  parameter int CNT_W     = $clog2(STAGE_DLY)
) (
  input  wire logic             CLK,
  input  wire logic             RN,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  input  wire logic             i_ld,
  input  wire logic [CNT_W-1:0] i_ld_val,
  output logic                  o_tc
);
  localparam logic [CNT_W-1:0] C_TC = CNT_W'(STAGE_DLY - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == C_TC);

endmodule
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__pwr_seq
// Staged header-switch sequencer with isolation control.
// Optional rail supervision: GF180MCU_PWR_SEQ_RAIL_CHECK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__pwr_seq
  import gf180mcu_fd_sc_mcu7t5v0__pwr_pkg::*;
#(
  parameter int NUM_STAGES = 8,
  parameter int STAGE_DLY  = 16,
  parameter int CNT_W      = $clog2(STAGE_DLY)
) (
  input wire logic CLK,
  input wire logic RN,
  gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if.slave bus
);

  pwr_state_t            r_state, w_state_nxt;
  logic [NUM_STAGES-1:0] r_sw_en, w_sw_en_nxt;
  logic                  r_iso_en, w_iso_en_nxt;
  logic                  r_pwr_good, w_pwr_good_nxt;
  logic                  r_busy;
  logic                  w_dly_tc;
  logic                  w_dly_en;
  logic                  w_dly_clr;
  logic                  w_settle_ok;
  logic                  w_settle_to;
  logic                  w_rail_drop;
  logic                  w_fault;

  // Any state change restarts the stage timer, so reversals get a full delay.
  assign w_dly_clr = (w_state_nxt != r_state);
  assign w_dly_en  = pwr_is_busy(r_state);

  gf180mcu_fd_sc_mcu7t5v0__pwr_seq_dly #(
    .STAGE_DLY (STAGE_DLY),
    .CNT_W     (CNT_W)
  ) u_dly (
    .CLK      (CLK),
    .RN       (RN),
    .i_clr    (w_dly_clr),
    .i_en     (w_dly_en),
    .i_ld     (1'b0),
    .i_ld_val ('0),
    .o_tc     (w_dly_tc)
  );

`ifdef GF180MCU_PWR_SEQ_RAIL_CHECK_EN
  localparam int SETTLE_MAX = PWR_SETTLE_TIMEOUT_MULT * STAGE_DLY;
  localparam int ST_W       = $clog2(SETTLE_MAX);

  logic [ST_W-1:0] r_settle_cnt;
  logic [1:0]      r_low_cnt;
  logic            r_fault;
  logic            w_set_fault;

  assign w_settle_ok = (r_settle_cnt >= ST_W'(STAGE_DLY - 1)) && bus.RAIL_OK;
  assign w_settle_to = (r_settle_cnt == ST_W'(SETTLE_MAX - 1)) && !bus.RAIL_OK;
  assign w_rail_drop = (r_state == ST_ON) && !bus.RAIL_OK &&
                       (r_low_cnt == 2'(PWR_RAIL_DROP_CYCLES - 1));
  assign w_set_fault = ((r_state == ST_SETTLE) && bus.PWR_REQ && w_settle_to) || w_rail_drop;
  assign w_fault     = r_fault;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_settle_cnt <= '0;
      r_low_cnt    <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + ST_W'(1) : '0;
      r_low_cnt    <= ((r_state == ST_ON) && !bus.RAIL_OK) ? r_low_cnt + 2'd1 : 2'd0;
      r_fault      <= r_fault | w_set_fault;
    end
  end

  assign bus.FAULT = r_fault;
`else
  assign w_settle_ok = w_dly_tc;
  assign w_settle_to = 1'b0;
  assign w_rail_drop = 1'b0;
  assign w_fault     = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_sw_en_nxt    = r_sw_en;
    w_iso_en_nxt   = r_iso_en;
    w_pwr_good_nxt = r_pwr_good;
    unique case (r_state)
      ST_OFF: begin
        if (bus.PWR_REQ && !w_fault) begin
          w_state_nxt = ST_UP;
          w_sw_en_nxt = NUM_STAGES'(1);
        end
      end
      ST_UP: begin
        if (!bus.PWR_REQ) begin
          w_state_nxt = ST_DOWN;
        end else if (w_dly_tc) begin
          // Also covers a reversal that re-entered UP with every switch still on.
          w_sw_en_nxt = {r_sw_en[NUM_STAGES-2:0], 1'b1};
          if (&r_sw_en[NUM_STAGES-2:0]) w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!bus.PWR_REQ || w_settle_to) begin
          w_state_nxt = ST_DOWN;
        end else if (w_settle_ok) begin
          w_state_nxt    = ST_ON;
          w_iso_en_nxt   = 1'b0;
          w_pwr_good_nxt = 1'b1;
        end
      end
      ST_ON: begin
        if (!bus.PWR_REQ || w_rail_drop) begin
          w_state_nxt    = ST_DOWN;
          w_iso_en_nxt   = 1'b1;
          w_pwr_good_nxt = 1'b0;
        end
      end
      ST_DOWN: begin
        if (bus.PWR_REQ && !w_fault) begin
          w_state_nxt = ST_UP;
        end else if (w_dly_tc) begin
          w_sw_en_nxt = {1'b0, r_sw_en[NUM_STAGES-1:1]};
          if (!r_sw_en[1]) w_state_nxt = ST_OFF;
        end
      end
      default: begin
        w_state_nxt    = ST_OFF;
        w_sw_en_nxt    = '0;
        w_iso_en_nxt   = 1'b1;
        w_pwr_good_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state    <= ST_OFF;
      r_sw_en    <= '0;
      r_iso_en   <= 1'b1;
      r_pwr_good <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sw_en    <= w_sw_en_nxt;
      r_iso_en   <= w_iso_en_nxt;
      r_pwr_good <= w_pwr_good_nxt;
      r_busy     <= pwr_is_busy(w_state_nxt);
    end
  end

  assign bus.SW_EN    = r_sw_en;
  assign bus.ISO_EN   = r_iso_en;
  assign bus.PWR_GOOD = r_pwr_good;
  assign bus.BUSY     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__pwr_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu7t5v0__pwr_seq
// Directed timing scenarios plus randomized requests against a stage-count model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__pwr_seq;
  localparam int N = 4;
  localparam int D = 3;

  logic CLK;
  logic RN;
  int   total = 0;
  int   bad   = 0;

  gf180mcu_fd_sc_mcu7t5v0__pwr_seq_if #(.NUM_STAGES(N)) bus ();

  gf180mcu_fd_sc_mcu7t5v0__pwr_seq #(
    .NUM_STAGES (N),
    .STAGE_DLY  (D)
  ) dut (
    .CLK (CLK),
    .RN  (RN),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: phase name, number of enabled stages, cycles since last event.
  typedef enum int {M_OFF, M_UP, M_SET, M_ON, M_DN} mphase_t;
  mphase_t m_ph;
  int      m_n;
  int      m_t;

  function automatic void model_reset();
    m_ph = M_OFF; m_n = 0; m_t = 0;
  endfunction

  function automatic void model_edge(input bit req);
    case (m_ph)
      M_OFF: if (req) begin m_ph = M_UP; m_n = 1; m_t = 0; end
      M_UP:  if (!req) begin m_ph = M_DN; m_t = 0; end
             else begin
               m_t++;
               if (m_t == D) begin
                 m_t = 0;
                 if (m_n < N) m_n++;
                 if (m_n == N) m_ph = M_SET;
               end
             end
      M_SET: if (!req) begin m_ph = M_DN; m_t = 0; end
             else begin m_t++; if (m_t == D) m_ph = M_ON; end
      M_ON:  if (!req) begin m_ph = M_DN; m_t = 0; end
      M_DN:  if (req) begin m_ph = M_UP; m_t = 0; end
             else begin
               m_t++;
               if (m_t == D) begin
                 m_t = 0; m_n--;
                 if (m_n == 0) m_ph = M_OFF;
               end
             end
      default: m_ph = M_OFF;
    endcase
  endfunction

  task automatic do_reset();
    RN = 1'b0;
    bus.PWR_REQ = 1'b0;
`ifdef GF180MCU_PWR_SEQ_RAIL_CHECK_EN
    bus.RAIL_OK = 1'b1;
`endif
    repeat (2) @(posedge CLK);
    #1 RN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.SW_EN !== 4'b0000 || bus.ISO_EN !== 1'b1 || bus.PWR_GOOD !== 1'b0 || bus.BUSY !== 1'b0) begin
      $display("FAIL reset: sw=%b iso=%b pg=%b busy=%b, want 0000 1 0 0",
               bus.SW_EN, bus.ISO_EN, bus.PWR_GOOD, bus.BUSY);
      bad++;
    end
  endtask

  task automatic test_power_up();
    logic [3:0] exp_sw;
    do_reset();
    bus.PWR_REQ = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(posedge CLK); #1;
      exp_sw = (e < 3) ? 4'b0001 : (e < 6) ? 4'b0011 : (e < 9) ? 4'b0111 : 4'b1111;
      total++;
      if (bus.SW_EN !== exp_sw || bus.PWR_GOOD !== (e >= 12) || bus.ISO_EN !== (e < 12) ||
          bus.BUSY !== (e <= 11)) begin
        $display("FAIL power_up e=%0d: sw=%b pg=%b iso=%b busy=%b, want %b %b %b %b",
                 e, bus.SW_EN, bus.PWR_GOOD, bus.ISO_EN, bus.BUSY,
                 exp_sw, (e >= 12), (e < 12), (e <= 11));
        bad++;
      end
    end
  endtask

  task automatic test_power_down();
    logic [3:0] exp_sw;
    bus.PWR_REQ = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      @(posedge CLK); #1;
      exp_sw = (e < 3) ? 4'b1111 : (e < 6) ? 4'b0111 : (e < 9) ? 4'b0011 :
               (e < 12) ? 4'b0001 : 4'b0000;
      total++;
      if (bus.SW_EN !== exp_sw || bus.PWR_GOOD !== 1'b0 || bus.ISO_EN !== 1'b1 ||
          bus.BUSY !== (e < 12)) begin
        $display("FAIL power_down e=%0d: sw=%b pg=%b iso=%b busy=%b, want %b 0 1 %b",
                 e, bus.SW_EN, bus.PWR_GOOD, bus.ISO_EN, bus.BUSY, exp_sw, (e < 12));
        bad++;
      end
    end
  endtask

  task automatic test_up_reversal();
    logic [3:0] exp_sw;
    do_reset();
    bus.PWR_REQ = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(posedge CLK); #1;
      if (e == 3) bus.PWR_REQ = 1'b0;
      exp_sw = (e < 3) ? 4'b0001 : (e < 7) ? 4'b0011 : (e < 10) ? 4'b0001 : 4'b0000;
      total++;
      if (bus.SW_EN !== exp_sw || bus.PWR_GOOD !== 1'b0 || bus.BUSY !== (e < 10)) begin
        $display("FAIL up_reversal e=%0d: sw=%b pg=%b busy=%b, want %b 0 %b",
                 e, bus.SW_EN, bus.PWR_GOOD, bus.BUSY, exp_sw, (e < 10));
        bad++;
      end
    end
  endtask

  task automatic test_down_reversal();
    logic [3:0] exp_sw;
    do_reset();
    bus.PWR_REQ = 1'b1;
    repeat (13) @(posedge CLK);
    #1 bus.PWR_REQ = 1'b0;
    for (int e = 0; e <= 18; e++) begin
      @(posedge CLK); #1;
      if (e == 6) bus.PWR_REQ = 1'b1;
      exp_sw = (e < 3) ? 4'b1111 : (e < 6) ? 4'b0111 : (e < 10) ? 4'b0011 :
               (e < 13) ? 4'b0111 : 4'b1111;
      total++;
      if (bus.SW_EN !== exp_sw || bus.PWR_GOOD !== (e >= 16) || bus.ISO_EN !== (e < 16)) begin
        $display("FAIL down_reversal e=%0d: sw=%b pg=%b iso=%b, want %b %b %b",
                 e, bus.SW_EN, bus.PWR_GOOD, bus.ISO_EN, exp_sw, (e >= 16), (e < 16));
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    bus.PWR_REQ = 1'b1;
    repeat (7) @(posedge CLK);
    #1;
    total++;
    if (bus.SW_EN !== 4'b0111) begin
      $display("FAIL mid_ramp_pre: sw=%b, want 0111", bus.SW_EN);
      bad++;
    end
    RN = 1'b0;
    #1;
    total++;
    if (bus.SW_EN !== 4'b0000 || bus.ISO_EN !== 1'b1 || bus.PWR_GOOD !== 1'b0 || bus.BUSY !== 1'b0) begin
      $display("FAIL mid_ramp_async: sw=%b iso=%b pg=%b busy=%b, want 0000 1 0 0",
               bus.SW_EN, bus.ISO_EN, bus.PWR_GOOD, bus.BUSY);
      bad++;
    end
    bus.PWR_REQ = 1'b0;
    #2 RN = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(posedge CLK); #1;
      total++;
      if (bus.SW_EN !== 4'b0000 || bus.ISO_EN !== 1'b1 || bus.PWR_GOOD !== 1'b0 || bus.BUSY !== 1'b0) begin
        $display("FAIL mid_ramp_idle e=%0d: sw=%b iso=%b pg=%b busy=%b, want 0000 1 0 0",
                 e, bus.SW_EN, bus.ISO_EN, bus.PWR_GOOD, bus.BUSY);
        bad++;
      end
    end
  endtask

  task automatic test_random();
    int         hold;
    logic [3:0] exp_sw;
    do_reset();
    model_reset();
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        bus.PWR_REQ = ~bus.PWR_REQ;
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 45) : $urandom_range(1, 14);
      end
      hold--;
      @(posedge CLK);
      model_edge(bus.PWR_REQ);
      #1;
      exp_sw = 4'((1 << m_n) - 1);
      total++;
      if (bus.SW_EN !== exp_sw) begin
        $display("FAIL rand_sw c=%0d: got %b, want %b", c, bus.SW_EN, exp_sw);
        bad++;
      end
      total++;
      if (bus.PWR_GOOD !== (m_ph == M_ON) || bus.ISO_EN !== (m_ph != M_ON)) begin
        $display("FAIL rand_pg c=%0d: pg=%b iso=%b, want %b %b",
                 c, bus.PWR_GOOD, bus.ISO_EN, (m_ph == M_ON), (m_ph != M_ON));
        bad++;
      end
      total++;
      if (bus.BUSY !== (m_ph == M_UP || m_ph == M_SET || m_ph == M_DN)) begin
        $display("FAIL rand_busy c=%0d: got %b, want %b",
                 c, bus.BUSY, (m_ph == M_UP || m_ph == M_SET || m_ph == M_DN));
        bad++;
      end
    end
  endtask

`ifdef GF180MCU_PWR_SEQ_RAIL_CHECK_EN
  task automatic test_rail_fault();
    logic [3:0] exp_sw;
    do_reset();
    bus.RAIL_OK = 1'b0;
    bus.PWR_REQ = 1'b1;
    for (int e = 0; e <= 41; e++) begin
      @(posedge CLK); #1;
      exp_sw = (e < 3) ? 4'b0001 : (e < 6) ? 4'b0011 : (e < 9) ? 4'b0111 : (e < 24) ? 4'b1111 :
               (e < 27) ? 4'b0111 : (e < 30) ? 4'b0011 : (e < 33) ? 4'b0001 : 4'b0000;
      total++;
      if (bus.SW_EN !== exp_sw || bus.FAULT !== (e >= 21) || bus.PWR_GOOD !== 1'b0 ||
          bus.BUSY !== (e < 33)) begin
        $display("FAIL rail_fault e=%0d: sw=%b fault=%b pg=%b busy=%b, want %b %b 0 %b",
                 e, bus.SW_EN, bus.FAULT, bus.PWR_GOOD, bus.BUSY, exp_sw, (e >= 21), (e < 33));
        bad++;
      end
    end
    do_reset();
    total++;
    if (bus.FAULT !== 1'b0) begin
      $display("FAIL rail_fault_clear: fault=%b, want 0", bus.FAULT);
      bad++;
    end
    bus.PWR_REQ = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (bus.SW_EN !== 4'b0001) begin
      $display("FAIL rail_fault_restart: sw=%b, want 0001", bus.SW_EN);
      bad++;
    end
  endtask
`endif

  initial begin
    RN = 1'b0;
    bus.PWR_REQ = 1'b0;
`ifdef GF180MCU_PWR_SEQ_RAIL_CHECK_EN
    bus.RAIL_OK = 1'b1;
`endif
    test_reset();
    test_power_up();
    test_power_down();
    test_up_reversal();
    test_down_reversal();
    test_reset_mid_ramp();
    test_random();
`ifdef GF180MCU_PWR_SEQ_RAIL_CHECK_EN
    test_rail_fault();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
